// File: rtl/rgb2ycbcr_422.sv
// 10-bit RGB to 8-bit BT.601 studio-range YCbCr, 3-cycle MAC pipeline,
// with optional 4:2:2 interleaved chroma on oC driven by a pixel-phase register.
module rgb2ycbcr_422 #(
  parameter int LATENCY = 3,
  parameter int RND     = 512
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic [9:0] iR,
  input  logic [9:0] iG,
  input  logic [9:0] iB,
  input  logic       iDVAL,
  input  logic       iSOL,
  input  logic       iMODE422,
  output logic [7:0] oY,
  output logic [7:0] oCb,
  output logic [7:0] oCr,
  output logic [7:0] oC,
  output logic       oPHASE,
  output logic       oDVAL
);

  if (LATENCY != 3) begin : g_bad_latency
    $error("rgb2ycbcr_422 only supports LATENCY = 3");
  end

  localparam logic signed [8:0] K_Y_R  =  9'sd66;
  localparam logic signed [8:0] K_Y_G  =  9'sd129;
  localparam logic signed [8:0] K_Y_B  =  9'sd25;
  localparam logic signed [8:0] K_CB_R = -9'sd38;
  localparam logic signed [8:0] K_CB_G = -9'sd74;
  localparam logic signed [8:0] K_CB_B =  9'sd112;
  localparam logic signed [8:0] K_CR_R =  9'sd112;
  localparam logic signed [8:0] K_CR_G = -9'sd94;
  localparam logic signed [8:0] K_CR_B = -9'sd18;

  localparam logic signed [21:0] Y_OFF = 22'(16384 + RND);
  localparam logic signed [21:0] C_OFF = 22'(131072 + RND);

  function automatic logic signed [19:0] mul(input logic [9:0] x, input logic signed [8:0] k);
    return $signed({10'b0, x}) * 20'(k);
  endfunction

  // Arithmetic >>10 then clamp; negatives land on the low bound.
  function automatic logic [7:0] clamp(input logic signed [21:0] s, input logic signed [21:0] hi);
    logic signed [21:0] v;
    v = s >>> 10;
    if (v < 22'sd16)  return 8'd16;
    else if (v > hi)  return hi[7:0];
    else              return v[7:0];
  endfunction

  // Stage 1: products
  logic signed [19:0] p_q [9];
  logic signed [19:0] p_d [9];
  logic               dv1_q, sol1_q, mode1_q;
  // Stage 2: sums
  logic signed [21:0] sy_q, scb_q, scr_q;
  logic signed [21:0] sy_d, scb_d, scr_d;
  logic               dv2_q, sol2_q, mode2_q;
  // Stage 3: outputs and 4:2:2 state
  logic [7:0] y_q, cb_q, cr_q, c_q;
  logic [7:0] y_d, cb_d, cr_d, c_d;
  logic       ph_q, ph_d, dval_q;
  logic       phase_q, phase_d;
  logic [7:0] held_cr_q, held_cr_d;

  always_comb begin
    p_d[0] = mul(iR, K_Y_R);
    p_d[1] = mul(iG, K_Y_G);
    p_d[2] = mul(iB, K_Y_B);
    p_d[3] = mul(iR, K_CB_R);
    p_d[4] = mul(iG, K_CB_G);
    p_d[5] = mul(iB, K_CB_B);
    p_d[6] = mul(iR, K_CR_R);
    p_d[7] = mul(iG, K_CR_G);
    p_d[8] = mul(iB, K_CR_B);
    sy_d   = 22'(p_q[0]) + 22'(p_q[1]) + 22'(p_q[2]) + Y_OFF;
    scb_d  = 22'(p_q[3]) + 22'(p_q[4]) + 22'(p_q[5]) + C_OFF;
    scr_d  = 22'(p_q[6]) + 22'(p_q[7]) + 22'(p_q[8]) + C_OFF;
  end

  // phase_q is the phase the next valid pixel takes unless it carries SOL.
  always_comb begin
    y_d       = clamp(sy_q, 22'sd235);
    cb_d      = clamp(scb_q, 22'sd240);
    cr_d      = clamp(scr_q, 22'sd240);
    ph_d      = phase_q;
    phase_d   = phase_q;
    held_cr_d = held_cr_q;
    if (dv2_q) begin
      ph_d    = sol2_q ? 1'b0 : phase_q;
      phase_d = ~ph_d;
      if (!ph_d) held_cr_d = cr_d;
    end
    c_d = (mode2_q && ph_d) ? held_cr_q : cb_d;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int i = 0; i < 9; i++) p_q[i] <= '0;
      dv1_q     <= 1'b0;
      sol1_q    <= 1'b0;
      mode1_q   <= 1'b0;
      sy_q      <= '0;
      scb_q     <= '0;
      scr_q     <= '0;
      dv2_q     <= 1'b0;
      sol2_q    <= 1'b0;
      mode2_q   <= 1'b0;
      y_q       <= '0;
      cb_q      <= '0;
      cr_q      <= '0;
      c_q       <= '0;
      ph_q      <= 1'b0;
      dval_q    <= 1'b0;
      phase_q   <= 1'b0;
      held_cr_q <= '0;
    end else begin
      for (int i = 0; i < 9; i++) p_q[i] <= p_d[i];
      dv1_q     <= iDVAL;
      sol1_q    <= iSOL & iDVAL;
      mode1_q   <= iMODE422;
      sy_q      <= sy_d;
      scb_q     <= scb_d;
      scr_q     <= scr_d;
      dv2_q     <= dv1_q;
      sol2_q    <= sol1_q;
      mode2_q   <= mode1_q;
      y_q       <= y_d;
      cb_q      <= cb_d;
      cr_q      <= cr_d;
      c_q       <= c_d;
      ph_q      <= ph_d;
      dval_q    <= dv2_q;
      phase_q   <= phase_d;
      held_cr_q <= held_cr_d;
    end
  end

  assign oY     = y_q;
  assign oCb    = cb_q;
  assign oCr    = cr_q;
  assign oC     = c_q;
  assign oPHASE = ph_q;
  assign oDVAL  = dval_q;

endmodule

// File: tb/tb_rgb2ycbcr_422.sv
// Bench for rgb2ycbcr_422: scripted vector table, random traffic, reset-in-flight,
// all checked through a due-cycle-stamped expected queue.
module tb_rgb2ycbcr_422;

  localparam int W = 49; // {due[15:0], y, cb, cr, c, ph}

  typedef struct {
    logic [9:0] r, g, b;
    logic       dv, sol, mode;
    logic [7:0] y, cb, cr, c;
    logic       ph;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] r_in, g_in, b_in;
  logic       dval_in, sol_in, mode_in;
  logic [7:0] y_o, cb_o, cr_o, c_o;
  logic       ph_o, dval_o;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int streak = 0;
  int max_streak = 0;
  logic [W-1:0] exp_q[$];
  logic       m_phase = 1'b0;
  logic [7:0] m_held = 8'd0;
  vec_t tbl[19];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgb2ycbcr_422 dut (
    .iCLK(clk), .iRESET(rst),
    .iR(r_in), .iG(g_in), .iB(b_in),
    .iDVAL(dval_in), .iSOL(sol_in), .iMODE422(mode_in),
    .oY(y_o), .oCb(cb_o), .oCr(cr_o), .oC(c_o),
    .oPHASE(ph_o), .oDVAL(dval_o)
  );

  function automatic logic [7:0] clampf(input int v, input int hi);
    if (v < 16) return 8'd16;
    if (v > hi) return 8'(hi);
    return 8'(v);
  endfunction

  function automatic vec_t mk(input int rr, gg, bb, input logic dv, ss, mm,
                              input int y, cb, cr, c, input logic ph);
    vec_t v;
    v.r = 10'(rr); v.g = 10'(gg); v.b = 10'(bb);
    v.dv = dv; v.sol = ss; v.mode = mm;
    v.y = 8'(y); v.cb = 8'(cb); v.cr = 8'(cr); v.c = 8'(c); v.ph = ph;
    return v;
  endfunction

  task automatic drive(input logic [9:0] rr, gg, bb, input logic dv, ss, mm);
    @(posedge clk);
    #1;
    r_in = rr; g_in = gg; b_in = bb;
    dval_in = dv; sol_in = ss; mode_in = mm;
  endtask

  // Called right after drive(): the pixel appears 3 edges after cyc.
  task automatic push_exp(input logic [7:0] y, cb, cr, c, input logic ph);
    exp_q.push_back({16'(cyc + 3), y, cb, cr, c, ph});
    m_phase = ~ph;
    if (!ph) m_held = cr;
  endtask

  task automatic drive_model(input logic [9:0] rr, gg, bb, input logic dv, ss, mm);
    int ri, gi, bi;
    logic [7:0] y, cb, cr, c;
    logic ph;
    ri = int'(rr); gi = int'(gg); bi = int'(bb);
    y  = clampf((66*ri + 129*gi + 25*bi + 16384 + 512) >>> 10, 235);
    cb = clampf((-38*ri - 74*gi + 112*bi + 131072 + 512) >>> 10, 240);
    cr = clampf((112*ri - 94*gi - 18*bi + 131072 + 512) >>> 10, 240);
    ph = ss ? 1'b0 : m_phase;
    c  = (mm && ph) ? m_held : cb;
    drive(rr, gg, bb, dv, ss, mm);
    if (dv) push_exp(y, cb, cr, c, ph);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (dval_o !== 1'b0 || y_o !== 8'd0 || cb_o !== 8'd0 || cr_o !== 8'd0 ||
        c_o !== 8'd0 || ph_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got dval=%b y=%0d cb=%0d cr=%0d c=%0d ph=%b, want all 0",
               name, dval_o, y_o, cb_o, cr_o, c_o, ph_o);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    streak = dval_o ? streak + 1 : 0;
    if (streak > max_streak) max_streak = streak;
    if (exp_q.size() > 0 && exp_q[0][48:33] == 16'(cyc)) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (dval_o !== 1'b1 || y_o !== e[32:25] || cb_o !== e[24:17] ||
          cr_o !== e[16:9] || c_o !== e[8:1] || ph_o !== e[0]) begin
        n_bad++;
        $display("FAIL pixel@%0d: got dval=%b y=%0d cb=%0d cr=%0d c=%0d ph=%b, want dval=1 y=%0d cb=%0d cr=%0d c=%0d ph=%b",
                 cyc, dval_o, y_o, cb_o, cr_o, c_o, ph_o,
                 e[32:25], e[24:17], e[16:9], e[8:1], e[0]);
      end
    end else if (dval_o === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_dval@%0d: got oDVAL=1, want 0", cyc);
    end
  end

  initial begin
    rst = 1'b1;
    r_in = '0; g_in = '0; b_in = '0;
    dval_in = 1'b0; sol_in = 1'b0; mode_in = 1'b0;

    //          r     g     b    dv  sol mode  y    cb   cr   c    ph
    tbl[0]  = mk(0,    0,    0,    1, 0, 0,   16, 128, 128, 128, 0);
    tbl[1]  = mk(0,    0,    0,    0, 0, 0,    0,   0,   0,   0, 0);
    tbl[2]  = mk(0,    0,    0,    0, 0, 0,    0,   0,   0,   0, 0);
    tbl[3]  = mk(0,    0,    0,    0, 0, 0,    0,   0,   0,   0, 0);
    tbl[4]  = mk(1023, 1023, 1023, 1, 0, 0,  235, 128, 128, 128, 1);
    tbl[5]  = mk(1023, 0,    0,    1, 1, 0,   82,  90, 240,  90, 0);
    tbl[6]  = mk(0,    0,    1023, 1, 0, 0,   41, 240, 110, 240, 1);
    tbl[7]  = mk(1023, 0,    0,    1, 1, 1,   82,  90, 240,  90, 0);
    tbl[8]  = mk(0,    0,    1023, 1, 0, 1,   41, 240, 110, 240, 1);
    tbl[9]  = mk(0,    0,    0,    0, 0, 1,    0,   0,   0,   0, 0);
    tbl[10] = mk(0,    0,    0,    0, 0, 1,    0,   0,   0,   0, 0);
    tbl[11] = mk(1023, 0,    0,    1, 0, 1,   82,  90, 240,  90, 0);
    tbl[12] = mk(0,    0,    1023, 1, 0, 1,   41, 240, 110, 240, 1);
    tbl[13] = mk(1023, 0,    0,    1, 1, 1,   82,  90, 240,  90, 0);
    tbl[14] = mk(0,    0,    1023, 1, 0, 1,   41, 240, 110, 240, 1);
    tbl[15] = mk(1023, 1023, 1023, 1, 1, 1,  235, 128, 128, 128, 0);
    tbl[16] = mk(0,    0,    0,    1, 0, 1,   16, 128, 128, 128, 1);
    tbl[17] = mk(1023, 0,    0,    1, 0, 0,   82,  90, 240,  90, 0);
    tbl[18] = mk(0,    0,    1023, 1, 0, 1,   41, 240, 110, 240, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].dv, tbl[i].sol, tbl[i].mode);
      if (tbl[i].dv) push_exp(tbl[i].y, tbl[i].cb, tbl[i].cr, tbl[i].c, tbl[i].ph);
    end

    for (int i = 0; i < 40; i++) begin
      drive_model(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                  10'($urandom_range(0, 1023)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
    end
    drive(10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);

    #1;
    max_streak = 0;
    for (int i = 0; i < 8; i++) begin
      drive_model(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                  10'($urandom_range(0, 1023)), 1'b1, i == 0, 1'b1);
    end
    drive(10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (max_streak < 8) begin
      n_bad++;
      $display("FAIL full_rate_run: got %0d consecutive oDVAL, want 8", max_streak);
    end

    // Two pixels in flight (odd phase pending), then a one-cycle reset.
    drive(10'd1023, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    drive(10'd0, 10'd0, 10'd1023, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dval_in = 1'b0;
    exp_q.delete();
    m_phase = 1'b0;
    m_held = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("after_reset");
    repeat (5) @(posedge clk);
    drive(10'd1023, 10'd0, 10'd0, 1'b1, 1'b0, 1'b1);
    push_exp(8'd82, 8'd90, 8'd240, 8'd90, 1'b0);
    drive(10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);

    repeat (8) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d outstanding pixels, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
